// File: rtl/ex_stage_pkg.sv
// Shared opcode/alusel codes and multiplier FSM encoding for the execute stage.
package ex_stage_pkg;

  localparam int MUL_CYCLES_DEF = 32;

  localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
  localparam logic [2:0] ALUSEL_ARITH = 3'b100;

  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_ANDI  = 8'b0101_1001;
  localparam logic [7:0] OP_ORI   = 8'b0101_1010;
  localparam logic [7:0] OP_XORI  = 8'b0101_1011;
  localparam logic [7:0] OP_LUI   = 8'b0101_1100;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_MUL  = 2'd1,
    MS_DONE = 2'd2
  } mul_state_t;

  function automatic logic is_mul_op(input logic [2:0] alusel, input logic [7:0] aluop);
    return (alusel == ALUSEL_ARITH) && ((aluop == OP_MULT) || (aluop == OP_MULTU));
  endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Radix-2 iterative 32x32->64 multiplier, one shift-add per cycle; done pulses on the last add.
// start is only taken in IDLE; abort returns to IDLE without a done pulse.
module ex_stage_mul_iter
  import ex_stage_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        signed_i,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        idle,
  output logic        busy,
  output logic        done,
  output logic [63:0] prod
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

  mul_state_t       state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [63:0]      mcand, acc, acc_nxt;
  logic [31:0]      mplier, a_abs, b_abs;
  logic             neg;

  assign a_abs   = (signed_i && a[31]) ? -a : a;
  assign b_abs   = (signed_i && b[31]) ? -b : b;
  assign acc_nxt = acc + (mplier[0] ? mcand : 64'd0);
  // The final add is folded into prod so HI/LO can be written on the last MUL edge.
  assign prod    = neg ? -acc_nxt : acc_nxt;
  assign idle    = (state == MS_IDLE);
  assign busy    = (state == MS_MUL);
  assign done    = busy && !abort && (count == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      MS_IDLE: if (start && !abort) state_nxt = MS_MUL;
      MS_MUL: begin
        if (abort)               state_nxt = MS_IDLE;
        else if (count == LAST)  state_nxt = MS_DONE;
      end
      MS_DONE: state_nxt = MS_IDLE;
      default: state_nxt = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MS_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      neg    <= 1'b0;
    end else if (idle && start && !abort) begin
      mcand  <= {32'd0, a_abs};
      mplier <= b_abs;
      acc    <= '0;
      count  <= '0;
      neg    <= signed_i & (a[31] ^ b[31]);
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: logic/LUI/MFHI/MFLO result mux (fwd same cycle, MEM regs latency 1) plus iterative MULT/MULTU into HI/LO.
// Requests a stall for MUL_CYCLES+1 cycles per multiply; flush kills the op and aborts a multiply.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [2:0]  alusel_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic        fwd_wreg_o,
  output logic [4:0]  fwd_wd_o,
  output logic [31:0] fwd_wdata_o,
  output logic        wreg_o,
  output logic [4:0]  wd_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall_req_o
);

  logic        mul_op, mul_idle, mul_busy, mul_done;
  logic [63:0] mul_prod;
  logic [31:0] result;
  logic        res_vld;

  assign mul_op = is_mul_op(alusel_i, aluop_i);

  always_comb begin
    result  = '0;
    res_vld = 1'b0;
    if (alusel_i == ALUSEL_LOGIC) begin
      res_vld = 1'b1;
      case (aluop_i)
        OP_AND, OP_ANDI: result = reg1_i & reg2_i;
        OP_OR,  OP_ORI:  result = reg1_i | reg2_i;
        OP_XOR, OP_XORI: result = reg1_i ^ reg2_i;
        OP_NOR:          result = ~(reg1_i | reg2_i);
        OP_LUI:          result = reg2_i;
        default:         res_vld = 1'b0;
      endcase
    end else if (alusel_i == ALUSEL_ARITH) begin
      res_vld = 1'b1;
      case (aluop_i)
        OP_MFHI: result = hi_o;
        OP_MFLO: result = lo_o;
        default: res_vld = 1'b0;
      endcase
    end
  end

  // DONE is neither idle nor busy, so the MULT still held by ID cannot restart.
  assign stall_req_o = rst && !flush_i && ((mul_op && mul_idle) || mul_busy);
  assign fwd_wreg_o  = rst && wreg_i && res_vld && (wd_i != 5'd0) && !flush_i;
  assign fwd_wd_o    = rst ? wd_i : 5'd0;
  assign fwd_wdata_o = rst ? result : 32'd0;

  ex_stage_mul_iter #(.MUL_CYCLES(MUL_CYCLES)) u_mul_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (mul_op && !flush_i),
    .abort    (flush_i),
    .signed_i (aluop_i == OP_MULT),
    .a        (reg1_i),
    .b        (reg2_i),
    .idle     (mul_idle),
    .busy     (mul_busy),
    .done     (mul_done),
    .prod     (mul_prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wreg_o  <= 1'b0;
      wd_o    <= '0;
      wdata_o <= '0;
    end else if (stall_req_o || flush_i) begin
      wreg_o  <= 1'b0;
      wd_o    <= '0;
      wdata_o <= '0;
    end else begin
      wreg_o  <= fwd_wreg_o;
      wd_o    <= fwd_wd_o;
      wdata_o <= fwd_wdata_o;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (mul_done) begin
      hi_o <= mul_prod[63:32];
      lo_o <= mul_prod[31:0];
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed + randomized bench for ex_stage against a behavioural reference model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [2:0]  alusel_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        fwd_wreg_o;
  logic [4:0]  fwd_wd_o;
  logic [31:0] fwd_wdata_o;
  logic        wreg_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        stall_req_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi, exp_lo;

  ex_stage dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .alusel_i(alusel_i), .aluop_i(aluop_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .fwd_wreg_o(fwd_wreg_o), .fwd_wd_o(fwd_wd_o), .fwd_wdata_o(fwd_wdata_o),
    .wreg_o(wreg_o), .wd_o(wd_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
    .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wr, input logic fl);
    alusel_i = sel; aluop_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr; flush_i = fl;
  endtask

  // Reference: what each instruction computes, by name.
  task automatic ref_op(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic vld, output logic [31:0] r);
    vld = 1'b1;
    r   = 32'd0;
    if (sel == ALUSEL_LOGIC && (op == OP_AND || op == OP_ANDI))      r = a & b;
    else if (sel == ALUSEL_LOGIC && (op == OP_OR || op == OP_ORI))   r = a | b;
    else if (sel == ALUSEL_LOGIC && (op == OP_XOR || op == OP_XORI)) r = a ^ b;
    else if (sel == ALUSEL_LOGIC && op == OP_NOR)                    r = ~(a | b);
    else if (sel == ALUSEL_LOGIC && op == OP_LUI)                    r = b;
    else if (sel == ALUSEL_ARITH && op == OP_MFHI)                   r = exp_hi;
    else if (sel == ALUSEL_ARITH && op == OP_MFLO)                   r = exp_lo;
    else vld = 1'b0;
  endtask

  task automatic single(input string tag, input logic [2:0] sel, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd,
                        input logic wr, input logic fl);
    logic vld, ew;
    logic [31:0] r;
    drive(sel, op, a, b, wd, wr, fl);
    ref_op(sel, op, a, b, vld, r);
    ew = wr && vld && (wd != 5'd0) && !fl;
    #2;
    chk({tag, ":fwd_wreg"}, fwd_wreg_o, ew);
    chk({tag, ":fwd_wd"}, fwd_wd_o, wd);
    chk({tag, ":fwd_wdata"}, fwd_wdata_o, r);
    chk({tag, ":stall"}, stall_req_o, 0);
    tick();
    chk({tag, ":wreg_o"}, wreg_o, fl ? 1'b0 : ew);
    chk({tag, ":wd_o"}, wd_o, fl ? 5'd0 : wd);
    chk({tag, ":wdata_o"}, wdata_o, fl ? 32'd0 : r);
  endtask

  task automatic do_mul(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    int n;
    sa = $signed(a);
    sb = $signed(b);
    p  = sgn ? 64'(sa * sb) : ({32'd0, a} * {32'd0, b});
    drive(ALUSEL_ARITH, sgn ? OP_MULT : OP_MULTU, a, b, 5'd9, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (!stall_req_o) break;
      n++;
      tick();
    end
    chk({tag, ":stall_cycles"}, n, 33);
    chk({tag, ":hi"}, hi_o, p[63:32]);
    chk({tag, ":lo"}, lo_o, p[31:0]);
    chk({tag, ":wreg_o_during"}, wreg_o, 0);
    chk({tag, ":fwd_wreg"}, fwd_wreg_o, 0);
    exp_hi = p[63:32];
    exp_lo = p[31:0];
    tick();
    chk({tag, ":wreg_o_done"}, wreg_o, 0);
    drive(3'd0, 8'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  logic [7:0] logic_ops [8];
  logic [31:0] sv_hi, sv_lo;

  initial begin
    logic_ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    rst = 1'b0;
    drive(ALUSEL_LOGIC, OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd5, 1'b1, 1'b0);
    #12;
    chk("rst:wreg_o", wreg_o, 0);
    chk("rst:wd_o", wd_o, 0);
    chk("rst:wdata_o", wdata_o, 0);
    chk("rst:hi", hi_o, 0);
    chk("rst:lo", lo_o, 0);
    chk("rst:fwd_wreg", fwd_wreg_o, 0);
    chk("rst:fwd_wdata", fwd_wdata_o, 0);
    chk("rst:stall", stall_req_o, 0);
    rst = 1'b1;
    tick();

    single("and", ALUSEL_LOGIC, OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd5, 1'b1, 1'b0);
    chk("and:lit_wdata", wdata_o, 32'h00F000F0);
    chk("and:lit_fwd", fwd_wdata_o, 32'h00F000F0);
    single("nor", ALUSEL_LOGIC, OP_NOR, 32'd0, 32'd0, 5'd2, 1'b1, 1'b0);
    chk("nor:lit", wdata_o, 32'hFFFFFFFF);
    single("lui", ALUSEL_LOGIC, OP_LUI, 32'd0, 32'h12340000, 5'd4, 1'b1, 1'b0);
    chk("lui:lit", wdata_o, 32'h12340000);
    single("wd0", ALUSEL_LOGIC, OP_OR, 32'h5, 32'h3, 5'd0, 1'b1, 1'b0);
    single("unk", ALUSEL_LOGIC, 8'hFF, 32'h5, 32'h3, 5'd6, 1'b1, 1'b0);
    single("flush1", ALUSEL_LOGIC, OP_XOR, 32'h5, 32'h3, 5'd6, 1'b1, 1'b1);

    do_mul("mult_m3_5", 1'b1, 32'hFFFFFFFD, 32'd5);
    chk("mult_m3_5:hi_lit", hi_o, 32'hFFFFFFFF);
    chk("mult_m3_5:lo_lit", lo_o, 32'hFFFFFFF1);
    single("mflo", ALUSEL_ARITH, OP_MFLO, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0);
    chk("mflo:lit", wdata_o, 32'hFFFFFFF1);
    single("mfhi", ALUSEL_ARITH, OP_MFHI, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0);

    do_mul("multu_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_max:hi_lit", hi_o, 32'hFFFFFFFE);
    chk("multu_max:lo_lit", lo_o, 32'h00000001);
    do_mul("mult_minint", 1'b1, 32'h80000000, 32'h80000000);
    for (int i = 0; i < 6; i++)
      do_mul("mul_rand", i[0], $urandom, $urandom);

    for (int i = 0; i < 24; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 8)
        single("rand_logic", ALUSEL_LOGIC, logic_ops[k], $urandom, $urandom,
               5'($urandom_range(0, 31)), 1'($urandom), ($urandom_range(0, 4) == 0));
      else
        single("rand_mfx", ALUSEL_ARITH, (k == 8) ? OP_MFHI : OP_MFLO, $urandom, $urandom,
               5'($urandom_range(0, 31)), 1'($urandom), ($urandom_range(0, 4) == 0));
    end

    sv_hi = hi_o;
    sv_lo = lo_o;
    drive(ALUSEL_ARITH, OP_MULT, 32'd7, 32'd9, 5'd9, 1'b1, 1'b0);
    tick();
    for (int i = 1; i < 10; i++) tick();
    flush_i = 1'b1;
    #2;
    chk("flush:stall", stall_req_o, 0);
    chk("flush:fwd_wreg", fwd_wreg_o, 0);
    tick();
    drive(ALUSEL_LOGIC, OP_OR, 32'h1, 32'h2, 5'd8, 1'b1, 1'b0);
    #2;
    chk("flush:wreg_o", wreg_o, 0);
    chk("flush:hi", hi_o, sv_hi);
    chk("flush:lo", lo_o, sv_lo);
    chk("flush:stall_after", stall_req_o, 0);
    tick();
    chk("flush:or_wdata", wdata_o, 32'h3);
    do_mul("after_flush", 1'b0, 32'd7, 32'd9);

    drive(ALUSEL_ARITH, OP_MULT, 32'hFFFFFFF9, 32'd11, 5'd9, 1'b1, 1'b0);
    tick(); tick(); tick();
    #3;
    rst = 1'b0;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    chk("arst:stall", stall_req_o, 0);
    chk("arst:hi", hi_o, 0);
    chk("arst:lo", lo_o, 0);
    chk("arst:wreg_o", wreg_o, 0);
    chk("arst:wdata_o", wdata_o, 0);
    chk("arst:fwd_wd", fwd_wd_o, 0);
    chk("arst:fwd_wreg", fwd_wreg_o, 0);
    drive(ALUSEL_LOGIC, OP_ORI, 32'd0, 32'd1, 5'd7, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("ori:fwd_wdata", fwd_wdata_o, 32'd1);
    tick();
    chk("ori:wdata_o", wdata_o, 32'd1);
    chk("ori:wreg_o", wreg_o, 1);
    chk("ori:wd_o", wd_o, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
